mul_rr_arbiter: RTL and testbench

- Sequencer and round-robin arbiter that shares one 32x32 signed/unsigned multiplier datapath between two requesters.
- Each requester presents two operands and a signed-mode flag over a valid/ready handshake.
- The block launches the operands into the multiplier and waits a fixed latency.
- It then captures the 64-bit product and returns it, tagged with the requester id, over a valid/ready response channel.

---
 rtl/mul_rr_arbiter.sv | 109 ++++++++++
 tb/tb_mul_rr_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_rr_arbiter.sv
// Round-robin front end that shares one external WIDTHxWIDTH multiplier between
// two requesters, waits MUL_LAT edges for the product, then returns it tagged with the owner id.
module mul_rr_arbiter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [WIDTH-1:0]     req_a0,
  input  logic [WIDTH-1:0]     req_b0,
  input  logic                 req_signed0,
  input  logic [WIDTH-1:0]     req_a1,
  input  logic [WIDTH-1:0]     req_b1,
  input  logic                 req_signed1,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic                 mul_signed,
  input  logic [2*WIDTH-1:0]   mul_z,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_z
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MUL_LAT - 1);

  state_t           r_state;
  logic             r_ptr;
  logic [3:0]       r_cnt;

  logic             w_winner;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic             w_sel_signed;

  // A lone requester always wins; on contention the pointer breaks the tie.
  always_comb begin
    w_winner = r_ptr;
    if (req_valid == 2'b01)
      w_winner = 1'b0;
    else if (req_valid == 2'b10)
      w_winner = 1'b1;
  end

  // Gated by rst so the strobe stays low while the block is held in reset.
  assign w_accept     = rst && (r_state == IDLE) && (|req_valid);
  assign req_ready    = w_accept ? (w_winner ? 2'b10 : 2'b01) : 2'b00;
  assign w_sel_a      = w_winner ? req_a1 : req_a0;
  assign w_sel_b      = w_winner ? req_b1 : req_b0;
  assign w_sel_signed = w_winner ? req_signed1 : req_signed0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_ptr      <= 1'b0;
      r_cnt      <= 4'd0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_signed <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_z      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            mul_a      <= w_sel_a;
            mul_b      <= w_sel_b;
            mul_signed <= w_sel_signed;
            rsp_id     <= w_winner;
            r_ptr      <= ~w_winner;
            r_cnt      <= LAT_M1;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          // Counter was loaded with MUL_LAT-1 so capture lands on the MUL_LAT-th edge.
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            rsp_z     <= mul_z;
            rsp_valid <= 1'b1;
            r_state   <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Bench for mul_rr_arbiter: three instances (MUL_LAT 2, 1, 15) each paired with a pipelined
// multiplier model; instance 0 carries the functional scenarios.
module tb_mul_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [31:0] a0, b0, a1, b1;
  logic        s0, s1;
  logic        rsp_ready;

  logic [1:0]  rr [3];
  logic [31:0] ma [3];
  logic [31:0] mb [3];
  logic        ms [3];
  logic [63:0] mz [3];
  logic        rv [3];
  logic        rid [3];
  logic [63:0] rz [3];

  int   n_chk  = 0;
  int   n_fail = 0;
  logic exp_ptr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic exp_win(input logic [1:0] v, input logic p);
    if (v == 2'b11) return p;
    return v[1];
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    logic [63:0] prod;
    logic [63:0] pipe [15];
    always_comb prod = ref_mul(ma[g], mb[g], ms[g]);
    always_ff @(posedge clk) begin
      pipe[0] <= prod;
      for (int k = 1; k < 15; k++) pipe[k] <= pipe[k-1];
    end
    assign mz[g] = (L == 1) ? prod : pipe[(L >= 2) ? (L - 2) : 0];

    mul_rr_arbiter #(.WIDTH(32), .MUL_LAT(L)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(rr[g]),
      .req_a0(a0), .req_b0(b0), .req_signed0(s0),
      .req_a1(a1), .req_b1(b1), .req_signed1(s1),
      .mul_a(ma[g]), .mul_b(mb[g]), .mul_signed(ms[g]), .mul_z(mz[g]),
      .rsp_valid(rv[g]), .rsp_ready(rsp_ready), .rsp_id(rid[g]), .rsp_z(rz[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b1; exp_ptr = 1'b0;
    tick();
  endtask

  // Drives one request pattern, reports who got the strobe, the latency and the response.
  task automatic issue(input logic [1:0] v, output int w, output int lat,
                       output logic [63:0] z, output logic id);
    req_valid = v;
    #1;
    w = (rr[0] == 2'b01) ? 0 : ((rr[0] == 2'b10) ? 1 : -1);
    tick();
    req_valid = 2'b00;
    lat = 0;
    while (!rv[0] && lat < 40) begin tick(); lat++; end
    z = rz[0]; id = rid[0];
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 2'b11;
    #2;
    n_chk++; if (rr[0] !== 2'b00)   begin n_fail++; $display("FAIL reset_req_ready got=%b exp=00", rr[0]); end
    n_chk++; if (ma[0] !== 32'd0)   begin n_fail++; $display("FAIL reset_mul_a got=%h exp=0", ma[0]); end
    n_chk++; if (mb[0] !== 32'd0)   begin n_fail++; $display("FAIL reset_mul_b got=%h exp=0", mb[0]); end
    n_chk++; if (ms[0] !== 1'b0)    begin n_fail++; $display("FAIL reset_mul_signed got=%b exp=0", ms[0]); end
    n_chk++; if (rv[0] !== 1'b0)    begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rv[0]); end
    n_chk++; if (rid[0] !== 1'b0)   begin n_fail++; $display("FAIL reset_rsp_id got=%b exp=0", rid[0]); end
    n_chk++; if (rz[0] !== 64'd0)   begin n_fail++; $display("FAIL reset_rsp_z got=%h exp=0", rz[0]); end
    repeat (2) tick();
    req_valid = 2'b00; rst = 1'b1; exp_ptr = 1'b0;
    tick();
  endtask

  task automatic test_unsigned();
    int n;
    a0 = 32'hFFFF_FFFF; b0 = 32'hFFFF_FFFF; s0 = 1'b0;
    req_valid = 2'b01;
    #1;
    n_chk++; if (rr[0] !== 2'b01) begin n_fail++; $display("FAIL uns_grant got=%b exp=01", rr[0]); end
    tick();
    req_valid = 2'b00; exp_ptr = 1'b1;
    #1;
    n_chk++; if (rr[0] !== 2'b00) begin n_fail++; $display("FAIL uns_ready_pulse got=%b exp=00", rr[0]); end
    n_chk++; if (ms[0] !== 1'b0)  begin n_fail++; $display("FAIL uns_mul_signed got=%b exp=0", ms[0]); end
    n_chk++; if (ma[0] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL uns_mul_a got=%h exp=ffffffff", ma[0]); end
    n = 0;
    while (!rv[0] && n < 20) begin tick(); n++; end
    n_chk++; if (n != 2) begin n_fail++; $display("FAIL uns_latency got=%0d exp=2", n); end
    n_chk++; if (rz[0] !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL uns_rsp_z got=%h exp=fffffffe00000001", rz[0]); end
    n_chk++; if (rid[0] !== 1'b0) begin n_fail++; $display("FAIL uns_rsp_id got=%b exp=0", rid[0]); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    n_chk++; if (rv[0] !== 1'b0) begin n_fail++; $display("FAIL uns_rsp_drop got=%b exp=0", rv[0]); end
  endtask

  task automatic test_signed();
    int w, lat; logic [63:0] z; logic id;
    a1 = 32'hFFFF_FFFE; b1 = 32'h0000_0003; s1 = 1'b1;
    issue(2'b10, w, lat, z, id);
    exp_ptr = 1'b0;
    n_chk++; if (w != 1) begin n_fail++; $display("FAIL sgn_grant got=%0d exp=1", w); end
    n_chk++; if (z !== 64'hFFFF_FFFF_FFFF_FFFA) begin n_fail++; $display("FAIL sgn_rsp_z got=%h exp=fffffffffffffffa", z); end
    n_chk++; if (id !== 1'b1) begin n_fail++; $display("FAIL sgn_rsp_id got=%b exp=1", id); end
    a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF; s1 = 1'b1;
    issue(2'b10, w, lat, z, id);
    n_chk++; if (z !== 64'h0000_0000_0000_0001) begin n_fail++; $display("FAIL sgn_minus1_sq got=%h exp=1", z); end
    n_chk++; if (lat != 2) begin n_fail++; $display("FAIL sgn_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_random();
    int w, lat; logic [63:0] z; logic id; logic [1:0] v; logic ew; logic [63:0] ez;
    for (int i = 0; i < 10; i++) begin
      a0 = $urandom(); b0 = $urandom(); s0 = 1'($urandom_range(0, 1));
      a1 = $urandom(); b1 = $urandom(); s1 = 1'($urandom_range(0, 1));
      v  = 2'($urandom_range(1, 3));
      ew = exp_win(v, exp_ptr);
      ez = ew ? ref_mul(a1, b1, s1) : ref_mul(a0, b0, s0);
      issue(v, w, lat, z, id);
      exp_ptr = ~ew;
      n_chk++; if (w != int'(ew)) begin n_fail++; $display("FAIL rnd_grant[%0d] got=%0d exp=%0d", i, w, ew); end
      n_chk++; if (z !== ez) begin n_fail++; $display("FAIL rnd_rsp_z[%0d] got=%h exp=%h", i, z, ez); end
      n_chk++; if (id !== ew) begin n_fail++; $display("FAIL rnd_rsp_id[%0d] got=%b exp=%b", i, id, ew); end
    end
  endtask

  task automatic test_contention();
    logic [63:0] expz[$];
    logic        expid[$];
    logic        ew, reroll;
    logic [63:0] ez;
    logic        eid;
    int cyc, last, nacc, nrsp;
    cyc = 0; last = 0; nacc = 0; nrsp = 0; reroll = 1'b0; ew = 1'b0;
    a0 = $urandom(); b0 = $urandom(); s0 = 1'($urandom_range(0, 1));
    a1 = $urandom(); b1 = $urandom(); s1 = 1'($urandom_range(0, 1));
    rst = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b1; exp_ptr = 1'b0;
    #1;
    while (nrsp < 4 && cyc < 60) begin
      if (rv[0]) begin
        n_chk++;
        if (expid.size() == 0) begin
          n_fail++; $display("FAIL cont_spurious_rsp got=1 exp=0");
        end else begin
          ez = expz.pop_front(); eid = expid.pop_front();
          if (rid[0] !== eid || rz[0] !== ez) begin
            n_fail++; $display("FAIL cont_rsp[%0d] got id=%b z=%h exp id=%b z=%h", nrsp, rid[0], rz[0], eid, ez);
          end
        end
        nrsp++;
      end
      if (rr[0] != 2'b00) begin
        ew = exp_win(2'b11, exp_ptr);
        n_chk++; if (rr[0] !== (ew ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL cont_grant[%0d] got=%b exp_winner=%b", nacc, rr[0], ew); end
        if (nacc > 0) begin
          n_chk++; if (cyc - last != 4) begin n_fail++; $display("FAIL cont_interval[%0d] got=%0d exp=4", nacc, cyc - last); end
        end
        expid.push_back(ew);
        expz.push_back(ew ? ref_mul(a1, b1, s1) : ref_mul(a0, b0, s0));
        last = cyc; nacc++; exp_ptr = ~ew; reroll = 1'b1;
      end
      tick(); cyc++;
      if (reroll) begin
        if (ew) begin a1 = $urandom(); b1 = $urandom(); s1 = 1'($urandom_range(0, 1)); end
        else    begin a0 = $urandom(); b0 = $urandom(); s0 = 1'($urandom_range(0, 1)); end
        reroll = 1'b0;
      end
    end
    n_chk++; if (nrsp != 4) begin n_fail++; $display("FAIL cont_rsp_count got=%0d exp=4", nrsp); end
    req_valid = 2'b00; rsp_ready = 1'b0;
    repeat (6) tick();
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0; tick();
  endtask

  task automatic test_backpressure();
    logic ew; logic [63:0] ez; int n; int bad;
    a0 = $urandom(); b0 = $urandom(); s0 = 1'($urandom_range(0, 1));
    a1 = $urandom(); b1 = $urandom(); s1 = 1'($urandom_range(0, 1));
    req_valid = 2'b11;
    #1;
    ew = exp_win(2'b11, exp_ptr);
    ez = ew ? ref_mul(a1, b1, s1) : ref_mul(a0, b0, s0);
    n_chk++; if (rr[0] !== (ew ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL bp_grant got=%b exp_winner=%b", rr[0], ew); end
    tick();
    exp_ptr = ~ew;
    req_valid = ew ? 2'b01 : 2'b10;
    n = 0;
    while (!rv[0] && n < 20) begin tick(); n++; end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_chk++;
      if (rv[0] !== 1'b1 || rz[0] !== ez || rid[0] !== ew || rr[0] !== 2'b00) begin
        n_fail++; bad++;
        $display("FAIL bp_hold[%0d] got v=%b id=%b z=%h rdy=%b exp v=1 id=%b z=%h rdy=00", i, rv[0], rid[0], rz[0], rr[0], ew, ez);
      end
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    #1;
    n_chk++; if (rr[0] !== (exp_ptr ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL bp_next_grant got=%b exp_winner=%b", rr[0], exp_ptr); end
    ez = exp_ptr ? ref_mul(a1, b1, s1) : ref_mul(a0, b0, s0);
    ew = exp_ptr;
    tick();
    req_valid = 2'b00; exp_ptr = ~ew;
    n = 0;
    while (!rv[0] && n < 20) begin tick(); n++; end
    n_chk++; if (rz[0] !== ez || rid[0] !== ew) begin n_fail++; $display("FAIL bp_second_rsp got id=%b z=%h exp id=%b z=%h", rid[0], rz[0], ew, ez); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_reset_busy();
    int w, lat, seen; logic [63:0] z; logic id;
    a0 = $urandom(); b0 = $urandom(); s0 = 1'b0;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    rst = 1'b0;
    #1;
    n_chk++;
    if (rv[0] !== 1'b0 || rid[0] !== 1'b0 || rz[0] !== 64'd0 || ma[0] !== 32'd0 ||
        mb[0] !== 32'd0 || ms[0] !== 1'b0 || rr[0] !== 2'b00) begin
      n_fail++;
      $display("FAIL rstbusy_outputs got v=%b id=%b z=%h a=%h b=%h s=%b rdy=%b exp all zero", rv[0], rid[0], rz[0], ma[0], mb[0], ms[0], rr[0]);
    end
    seen = 0;
    repeat (2) begin tick(); if (rv[0] !== 1'b0) seen++; end
    rst = 1'b1; exp_ptr = 1'b0;
    repeat (6) begin tick(); if (rv[0] !== 1'b0) seen++; end
    n_chk++; if (seen != 0) begin n_fail++; $display("FAIL rstbusy_no_rsp got=%0d exp=0", seen); end
    a0 = 32'd5; b0 = 32'd7; s0 = 1'b0;
    a1 = $urandom(); b1 = $urandom(); s1 = 1'b0;
    issue(2'b11, w, lat, z, id);
    exp_ptr = 1'b1;
    n_chk++; if (w != 0) begin n_fail++; $display("FAIL rstbusy_grant got=%0d exp=0", w); end
    n_chk++; if (z !== 64'h23) begin n_fail++; $display("FAIL rstbusy_rsp_z got=%h exp=23", z); end
    n_chk++; if (id !== 1'b0) begin n_fail++; $display("FAIL rstbusy_rsp_id got=%b exp=0", id); end
  endtask

  task automatic test_latency_sweep();
    int lat[3];
    int exp_lat[3];
    logic [63:0] ez;
    exp_lat = '{2, 1, 15};
    lat = '{-1, -1, -1};
    do_reset();
    a0 = $urandom(); b0 = $urandom(); s0 = 1'($urandom_range(0, 1));
    ez = ref_mul(a0, b0, s0);
    req_valid = 2'b01;
    #1;
    for (int g = 0; g < 3; g++) begin
      n_chk++; if (rr[g] !== 2'b01) begin n_fail++; $display("FAIL sweep_grant[%0d] got=%b exp=01", g, rr[g]); end
    end
    tick();
    req_valid = 2'b00;
    for (int n = 0; n < 20; n++) begin
      for (int g = 0; g < 3; g++) if (rv[g] === 1'b1 && lat[g] < 0) lat[g] = n;
      tick();
    end
    for (int g = 0; g < 3; g++) begin
      n_chk++; if (lat[g] != exp_lat[g]) begin n_fail++; $display("FAIL sweep_latency[%0d] got=%0d exp=%0d", g, lat[g], exp_lat[g]); end
      n_chk++; if (rz[g] !== ez) begin n_fail++; $display("FAIL sweep_rsp_z[%0d] got=%h exp=%h", g, rz[g], ez); end
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0; exp_ptr = 1'b0;
    a0 = '0; b0 = '0; s0 = 1'b0; a1 = '0; b1 = '0; s1 = 1'b0;
    #3;
    test_reset();
    test_unsigned();
    test_signed();
    test_random();
    test_contention();
    test_backpressure();
    test_reset_busy();
    test_latency_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

endmodule
